// File: rtl/mul_wb_queue.sv
// Multiplier writeback queue: tracks {op, dest} of issued multiplies in order and
// pairs each returned product with its tag. Optional checker: define MUL_WB_ERR_EN.
module mul_wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 5
) (
  input  logic                         mul_clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [2:0]                   issue_op,
  input  logic [DEST_W-1:0]            issue_dest,
  input  logic                         mul_resp_valid,
  output logic                         mul_resp_ready,
  input  logic [63:0]                  mul_result,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [DEST_W-1:0]            wb_dest,
  output logic [31:0]                  wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         mul_err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        op;
    logic [DEST_W-1:0] dest;
  } tag_t;

  tag_t        mem [DEPTH];
  tag_t        head;
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full           = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty          = (wptr == rptr);
  assign issue_ready    = !full;
  assign mul_resp_ready = !empty && (!wb_valid || wb_ready);
  assign push           = issue_valid && issue_ready;
  assign pop            = mul_resp_valid && mul_resp_ready;
  assign head           = mem[rptr[AW-1:0]];

  always_ff @(posedge mul_clk)
    if (push) mem[wptr[AW-1:0]] <= {issue_op, issue_dest};

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= '0;
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      // A pop refills the register even when the held word is consumed this cycle.
      if (pop) begin
        wb_valid <= 1'b1;
        wb_dest  <= head.dest;
        wb_data  <= head.op[0] ? mul_result[31:0] : mul_result[63:32];
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_WB_ERR_EN
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset)
      mul_err <= 1'b0;
    else if ((mul_resp_valid && empty) || (push && !$onehot(issue_op)))
      mul_err <= 1'b1;
  end
`else
  assign mul_err = 1'b0;
`endif

endmodule
